instruction_loader: RTL

- Write-side companion to the processor's 24-bit, word-aligned instruction memory.
- Accepts a byte stream (valid/ready) from a host link (UART RX or a debug port) and assembles the bytes into 24-bit instructions.
- Writes each instruction into the instruction memory at byte address 4*index.
- Holds the CPU in reset while a program is being loaded.

---
 rtl/instruction_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// instruction_loader: write-side companion to the 24-bit, word-aligned instruction memory.
// Assembles a host byte stream (16-bit big-endian count N, then N 3-byte MSB-first words)
// into instructions, writes word i at byte address 4*i, and holds the CPU in reset while
// a load session runs.
// Optional feature macro: INSTRUCTION_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and the sticky chk_err output.
module instruction_loader #(
    parameter int unsigned DEPTH = 140,
    parameter int unsigned AW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [23:0]   mem_wd,
    output logic          busy,
    output logic          done,
    output logic          overflow,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    output logic          chk_err,
`endif
    output logic          cpu_hold
);

    typedef enum logic [3:0] {
        IDLE, HDR_H, HDR_L, B0, B1, B2, WR, CSUM, FIN
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [23:0] word;
    logic        accept;
    logic        in_range;
    logic [16:0] idx_next;
    logic        last_word;
    state_t      after_last;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    logic        csum_bad;
`endif

    // Byte acceptance and write bookkeeping derived from the current state/index.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            HDR_H, HDR_L, B0, B1, B2, CSUM: in_ready = 1'b1;
            default:                         in_ready = 1'b0;
        endcase
        accept    = in_valid && in_ready;
        in_range  = ({16'd0, idx} < DEPTH);
        idx_next  = {1'b0, idx} + 17'd1;
        last_word = (idx_next >= {1'b0, cnt});
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        after_last = CSUM;
`else
        after_last = FIN;
`endif
    end

    assign cpu_hold = busy;

    // Session FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            idx      <= 16'd0;
            word     <= 24'd0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_wd   <= 24'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
            csum_bad <= 1'b0;
            chk_err  <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            // Running XOR of every stream byte except the checksum itself.
            if (accept && state != CSUM) begin
                csum <= csum ^ in_data;
            end
`endif
            case (state)
                IDLE: begin
                    // busy is still high in the cycle done shows, so start is ignored there.
                    if (done) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        state    <= HDR_H;
                        busy     <= 1'b1;
                        idx      <= 16'd0;
                        overflow <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
                        csum_bad <= 1'b0;
                        chk_err  <= 1'b0;
`endif
                    end
                end
                HDR_H: begin
                    if (accept) begin
                        cnt[15:8] <= in_data;
                        state     <= HDR_L;
                    end
                end
                HDR_L: begin
                    if (accept) begin
                        cnt[7:0] <= in_data;
                        state    <= ({cnt[15:8], in_data} != 16'd0) ? B0 : after_last;
                    end
                end
                B0: begin
                    if (accept) begin
                        word[23:16] <= in_data;
                        state       <= B1;
                    end
                end
                B1: begin
                    if (accept) begin
                        word[15:8] <= in_data;
                        state      <= B2;
                    end
                end
                B2: begin
                    // Present the write in the WR cycle; address/data update even when suppressed.
                    if (accept) begin
                        word[7:0] <= in_data;
                        mem_wd    <= {word[23:8], in_data};
                        mem_a     <= AW'({idx, 2'b00});
                        mem_we    <= in_range;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (!in_range) begin
                        overflow <= 1'b1;
                    end
                    idx   <= idx_next[15:0];
                    state <= last_word ? after_last : B0;
                end
                CSUM: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    if (accept) begin
                        csum_bad <= (in_data != csum);
                        state    <= FIN;
                    end
`else
                    state <= FIN;
`endif
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    chk_err <= chk_err | csum_bad;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
